// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM-stage data-memory controller.
// Holds the 2-bit FSM state encoding, datapath widths and the default
// read-data pattern returned by a failed load.
package mem_stage_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // FSM state encoding kept as plain constants so older blocks can share it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/reg16.sv
// Generic 16-bit enabled register cell with async active-low clear.
// Ports: clk, rst_n, en_i (load enable), d_i (next value), q_o (held value).
module reg16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wait_counter.sv
// Counts cycles spent waiting for a memory acknowledge.
// Ports: clk, rst_n, clr_i (synchronous clear, wins over enable),
//        en_i (increment), tc_c_o (count has reached LIMIT-1, combinational).
module wait_counter
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == CNT_W'(LIMIT - 32'd1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns an EX/MEM load/store into a req/ack SRAM
// transaction, stalls the pipeline while it is outstanding, flags unaligned
// accesses and timeouts, and forwards dump requests.
// Ports: clk, rst (async active-low); EXMem_* pipeline inputs; mem_* SRAM
// handshake; EXMem_read_data load result; Stall (combinational), Done, Err,
// DumpOut single-cycle pulses.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXMem_DMemEn,
  input  logic              EXMem_MemWrite,
  input  logic [DATA_W-1:0] EXMem_alu_out,
  input  logic [DATA_W-1:0] EXMem_write_data,
  input  logic              EXMem_DMemDump,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] EXMem_read_data,
  output logic              Stall,
  output logic              Done,
  output logic              Err,
  output logic              DumpOut
);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_we_q, mem_we_d;
  logic              done_q, done_d, err_q, err_d, dump_q, dump_d;
  logic              latch_en, rdata_en, stall_busy;
  logic [DATA_W-1:0] rdata_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  wait_counter #(.LIMIT(TIMEOUT)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_c_o (cnt_tc)
  );

  // Address and store data captured once at issue, held for the whole access
  reg16 u_addr_reg (
    .clk(clk), .rst_n(rst), .en_i(latch_en), .d_i(EXMem_alu_out), .q_o(mem_addr)
  );
  reg16 u_wdata_reg (
    .clk(clk), .rst_n(rst), .en_i(latch_en), .d_i(EXMem_write_data), .q_o(mem_wdata)
  );
  reg16 u_rdata_reg (
    .clk(clk), .rst_n(rst), .en_i(rdata_en), .d_i(rdata_d), .q_o(EXMem_read_data)
  );

  // Next-state and pulse decode
  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    rdata_en   = 1'b0;
    rdata_d    = mem_rdata;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    dump_d     = 1'b0;
    stall_busy = 1'b0;
    mem_we_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Dump outranks any access in the same instruction
        if (EXMem_DMemDump) begin
          dump_d = 1'b1;
        end else if (EXMem_DMemEn) begin
          stall_busy = 1'b1;
          if (EXMem_alu_out[0]) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            if (!EXMem_MemWrite) begin
              rdata_en = 1'b1;
              rdata_d  = ERR_DATA;
            end
          end else begin
            state_d  = ST_REQ;
            latch_en = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_busy = 1'b1;
        cnt_clr    = 1'b0;
        // Ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          state_d  = ST_RESP;
          done_d   = 1'b1;
          rdata_en = !mem_we_q;
        end else if (cnt_tc) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          if (!mem_we_q) begin
            rdata_en = 1'b1;
            rdata_d  = ERR_DATA;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Write strobe only lives while the request is outstanding
    if (latch_en) begin
      mem_we_d = EXMem_MemWrite;
    end else if (state_d == ST_REQ) begin
      mem_we_d = mem_we_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == ST_REQ);
      mem_we_q  <= mem_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dump_q    <= dump_d;
    end
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign DumpOut = dump_q;
  // Stall must drop as soon as reset asserts, even with a request pending
  assign Stall   = rst & stall_busy;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a per-cycle vector table plus
// hand-written timeout and mid-access reset sequences.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        EXMem_DMemEn, EXMem_MemWrite, EXMem_DMemDump;
  logic [15:0] EXMem_alu_out, EXMem_write_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, EXMem_read_data;
  logic        Stall, Done, Err, DumpOut;

  int n_chk;
  int n_fail;

  mem_stage_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .EXMem_DMemEn     (EXMem_DMemEn),
    .EXMem_MemWrite   (EXMem_MemWrite),
    .EXMem_alu_out    (EXMem_alu_out),
    .EXMem_write_data (EXMem_write_data),
    .EXMem_DMemDump   (EXMem_DMemDump),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .EXMem_read_data  (EXMem_read_data),
    .Stall            (Stall),
    .Done             (Done),
    .Err              (Err),
    .DumpOut          (DumpOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, we;
    logic [15:0] addr, wdata;
    logic        dump, ack;
    logic [15:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_done, e_err, e_dump;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic en, input logic we, input logic [15:0] a,
    input logic [15:0] wd, input logic dm, input logic ack, input logic [15:0] rd,
    input logic es, input logic erq, input logic ewe, input logic [15:0] ea,
    input logic [15:0] ewd, input logic ed, input logic ee, input logic edm,
    input logic [15:0] erd);
    vec_t v;
    v.rst = r; v.en = en; v.we = we; v.addr = a; v.wdata = wd; v.dump = dm;
    v.ack = ack; v.rdata = rd; v.e_stall = es; v.e_req = erq; v.e_we = ewe;
    v.e_addr = ea; v.e_wdata = ewd; v.e_done = ed; v.e_err = ee;
    v.e_dump = edm; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input logic dm, input logic ack,
                       input logic [15:0] rd);
    EXMem_DMemEn = en; EXMem_MemWrite = we; EXMem_alu_out = a;
    EXMem_write_data = wd; EXMem_DMemDump = dm; mem_ack = ack; mem_rdata = rd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  req_cycles;
    bit  err_seen;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);

    //             rst en we addr     wdata    dm ack rdata     st rq we addr     wdata    dn er du rd
    // Reset with a pending request: everything idle, Stall low
    vecs.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    // Aligned load to 0x0010, ack in first REQ cycle
    vecs.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'hBEEF));
    // Unaligned load to 0x0011: no request, Err with error data
    vecs.push_back(mk(1, 1, 0, 16'h0011, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'hBEEF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'hFFFF));
    // Dump together with an access request
    vecs.push_back(mk(1, 1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'hFFFF));
    // Store 0x1234 to 0x0020, four wait cycles then ack
    vecs.push_back(mk(1, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'hFFFF));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5555, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 16'hFFFF));
    // Stray acks in RESP and IDLE must not touch read data
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hAAAA, 0, 0, 0, 16'h0020, 16'h1234, 1, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hAAAA, 0, 0, 0, 16'h0020, 16'h1234, 0, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0020, 16'h1234, 0, 0, 0, 16'hFFFF));

    foreach (vecs[i]) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      rst = vecs[i].rst;
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dump,
            vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d Stall", i), 16'(Stall), 16'(vecs[i].e_stall));
      chk($sformatf("v%0d mem_req", i), 16'(mem_req), 16'(vecs[i].e_req));
      chk($sformatf("v%0d mem_we", i), 16'(mem_we), 16'(vecs[i].e_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d Done", i), 16'(Done), 16'(vecs[i].e_done));
      chk($sformatf("v%0d Err", i), 16'(Err), 16'(vecs[i].e_err));
      chk($sformatf("v%0d DumpOut", i), 16'(DumpOut), 16'(vecs[i].e_dump));
      chk($sformatf("v%0d read_data", i), EXMem_read_data, vecs[i].e_rd);
    end

    // Ack arriving on the 15th REQ cycle completes normally
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, (k == 15), 16'h2468);
      @(negedge clk);
      chk($sformatf("late_ack req k=%0d", k), 16'(mem_req), 16'd1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("late_ack Done", 16'(Done), 16'd1);
    chk("late_ack Err", 16'(Err), 16'd0);
    chk("late_ack read_data", EXMem_read_data, 16'h2468);

    // No ack at all: Err after exactly 15 REQ cycles
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0032, 16'h0000, 1'b0, 1'b0, 16'h0000);
    req_cycles = 0;
    err_seen = 1'b0;
    for (int k = 0; k < 40 && !err_seen; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (Err) err_seen = 1'b1;
    end
    chk("timeout Err seen", 16'(err_seen), 16'd1);
    chk("timeout req cycles", 16'(req_cycles), 16'd15);
    chk("timeout read_data", EXMem_read_data, 16'hFFFF);
    chk("timeout Done", 16'(Done), 16'd0);

    // Reset in the middle of an access
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h0050, 16'h7777, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h0050, 16'h7777, 1'b0, 1'b0, 16'h0000);
    chk("midreq mem_req before reset", 16'(mem_req), 16'd1);
    rst = 1'b0;
    #1;
    chk("midreq reset mem_req", 16'(mem_req), 16'd0);
    chk("midreq reset mem_we", 16'(mem_we), 16'd0);
    chk("midreq reset mem_addr", mem_addr, 16'h0000);
    chk("midreq reset mem_wdata", mem_wdata, 16'h0000);
    chk("midreq reset read_data", EXMem_read_data, 16'h0000);
    chk("midreq reset Stall", 16'(Stall), 16'd0);
    chk("midreq reset Done", 16'(Done), 16'd0);
    chk("midreq reset Err", 16'(Err), 16'd0);
    chk("midreq reset DumpOut", 16'(DumpOut), 16'd0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1111);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset Done k=%0d", k), 16'(Done), 16'd0);
      chk($sformatf("post_reset Err k=%0d", k), 16'(Err), 16'd0);
      chk($sformatf("post_reset mem_req k=%0d", k), 16'(mem_req), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
